// File: rtl/spi_sclk_engine.sv
// Programmable SPI serial-clock engine: run-time divider, CPOL/CPHA modes,
// N-cycle bursts with setup/hold half-periods and registered sample/shift strobes.
module spi_sclk_engine #(
  parameter int unsigned DIV_WIDTH  = 16,
  parameter int unsigned BITS_WIDTH = 6
) (
  input  logic                  clk_i,
  input  logic                  rst_i,
  input  logic                  en_i,
  input  logic                  start_i,
  input  logic [DIV_WIDTH-1:0]  div_i,
  input  logic [BITS_WIDTH-1:0] bits_i,
  input  logic                  cpol_i,
  input  logic                  cpha_i,
  output logic                  sclk_o,
  output logic                  lead_o,
  output logic                  trail_o,
  output logic                  sample_o,
  output logic                  shift_o,
  output logic                  busy_o,
  output logic                  done_o
);

  typedef enum logic [1:0] {IDLE, SETUP, RUN, HOLD} state_t;

  state_t                state_q, state_d;
  logic                  go_q, go_d;
  logic [DIV_WIDTH-1:0]  cnt_q, cnt_d;
  logic [DIV_WIDTH-1:0]  div_q, div_d;
  logic [BITS_WIDTH-1:0] bits_q, bits_d;
  logic [BITS_WIDTH:0]   edge_q, edge_d;
  logic                  cpol_q, cpol_d;
  logic                  cpha_q, cpha_d;
  logic                  sclk_d, lead_d, trail_d, sample_d, shift_d, busy_d, done_d;

  logic                  half_tc;
  logic [BITS_WIDTH:0]   edge_inc;
  logic [BITS_WIDTH:0]   edge_last;

  assign half_tc   = (cnt_q == div_q);
  assign edge_inc  = edge_q + 1'b1;
  assign edge_last = {bits_q, 1'b0};

  always_comb begin
    state_d = state_q;
    go_d    = 1'b0;
    cnt_d   = cnt_q;
    div_d   = div_q;
    bits_d  = bits_q;
    edge_d  = edge_q;
    cpol_d  = cpol_q;
    cpha_d  = cpha_q;
    sclk_d  = sclk_o;
    lead_d  = 1'b0;
    trail_d = 1'b0;
    busy_d  = busy_o;
    done_d  = 1'b0;

    // The accept edge only latches; the half-counter runs from that edge so
    // every later event lands on a multiple of (div+1). With div=0 the setup
    // interval has already elapsed when the accept is acted on.
    unique case (state_q)
      IDLE: begin
        sclk_d = cpol_i;
        busy_d = 1'b0;
        if (go_q) begin
          if (en_i) begin
            sclk_d = cpol_q;
            if (bits_q == '0) begin
              done_d = 1'b1;
            end else begin
              busy_d = 1'b1;
              if (half_tc) begin
                state_d = RUN;
                cnt_d   = '0;
              end else begin
                state_d = SETUP;
                cnt_d   = DIV_WIDTH'(1);
              end
            end
          end
        end else if (en_i && start_i) begin
          go_d   = 1'b1;
          div_d  = div_i;
          bits_d = bits_i;
          cpol_d = cpol_i;
          cpha_d = cpha_i;
          cnt_d  = '0;
          edge_d = '0;
        end
      end
      SETUP: begin
        if (half_tc) begin
          state_d = RUN;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      RUN: begin
        if (half_tc) begin
          cnt_d   = '0;
          sclk_d  = ~sclk_o;
          edge_d  = edge_inc;
          lead_d  = edge_inc[0];
          trail_d = ~edge_inc[0];
          if (edge_inc == edge_last) state_d = HOLD;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      HOLD: begin
        if (half_tc) begin
          state_d = IDLE;
          cnt_d   = '0;
          busy_d  = 1'b0;
          done_d  = 1'b1;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase

    if (state_q != IDLE && !en_i) begin
      state_d = IDLE;
      cnt_d   = '0;
      edge_d  = '0;
      sclk_d  = cpol_q;
      lead_d  = 1'b0;
      trail_d = 1'b0;
      busy_d  = 1'b0;
      done_d  = 1'b0;
    end

    sample_d = cpha_q ? trail_d : lead_d;
    shift_d  = cpha_q ? lead_d  : trail_d;
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q  <= IDLE;
      go_q     <= 1'b0;
      cnt_q    <= '0;
      div_q    <= '0;
      bits_q   <= '0;
      edge_q   <= '0;
      cpol_q   <= 1'b0;
      cpha_q   <= 1'b0;
      sclk_o   <= 1'b0;
      lead_o   <= 1'b0;
      trail_o  <= 1'b0;
      sample_o <= 1'b0;
      shift_o  <= 1'b0;
      busy_o   <= 1'b0;
      done_o   <= 1'b0;
    end else begin
      state_q  <= state_d;
      go_q     <= go_d;
      cnt_q    <= cnt_d;
      div_q    <= div_d;
      bits_q   <= bits_d;
      edge_q   <= edge_d;
      cpol_q   <= cpol_d;
      cpha_q   <= cpha_d;
      sclk_o   <= sclk_d;
      lead_o   <= lead_d;
      trail_o  <= trail_d;
      sample_o <= sample_d;
      shift_o  <= shift_d;
      busy_o   <= busy_d;
      done_o   <= done_d;
    end
  end

endmodule

// File: tb/tb_spi_sclk_engine.sv
// Directed bench for spi_sclk_engine: per-burst edge timing, strobe counts,
// latching, abort and reset behaviour against hand-computed edge numbers.
module tb_spi_sclk_engine;

  logic        clk_i = 1'b0;
  logic        rst_i, en_i, start_i, cpol_i, cpha_i;
  logic [15:0] div_i;
  logic [5:0]  bits_i;
  logic        sclk_o, lead_o, trail_o, sample_o, shift_o, busy_o, done_o;

  int n_checks = 0;
  int n_fail   = 0;

  // Per-burst observations (edge index e counts clk_i edges after E0)
  int   first_tog, last_tog, n_tog, n_lead, n_trail, n_done, done_at;
  int   n_busy, n_map_err, n_samp_hi, n_post, abort_at;
  logic busy_abort, sclk_abort, busy_end;
  logic [6:0] rst_vec;

  spi_sclk_engine #(.DIV_WIDTH(16), .BITS_WIDTH(6)) dut (
    .clk_i(clk_i), .rst_i(rst_i), .en_i(en_i), .start_i(start_i),
    .div_i(div_i), .bits_i(bits_i), .cpol_i(cpol_i), .cpha_i(cpha_i),
    .sclk_o(sclk_o), .lead_o(lead_o), .trail_o(trail_o),
    .sample_o(sample_o), .shift_o(shift_o), .busy_o(busy_o), .done_o(done_o)
  );

  always #5 clk_i = ~clk_i;

  task automatic step();
    @(posedge clk_i);
    #1;
  endtask

  task automatic check_eq(input string tag, input longint obs, input longint exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d", tag, obs, exp);
    end
  endtask

  // mode: 0 plain, 1 disturb inputs mid-burst, 2 abort after 3rd edge, 3 reset in RUN
  task automatic run(input logic [15:0] d, input logic [5:0] b, input logic pol,
                     input logic pha, input int ncyc, input int mode);
    logic prev_sclk;
    div_i = d; bits_i = b; cpol_i = pol; cpha_i = pha; start_i = 1'b1;
    step();
    start_i = 1'b0;
    first_tog = -1; last_tog = -1; n_tog = 0; n_lead = 0; n_trail = 0;
    n_done = 0; done_at = -1; n_busy = 0; n_map_err = 0; n_samp_hi = 0;
    n_post = 0; abort_at = 1000000; busy_abort = 1'bx; sclk_abort = 1'bx;
    rst_vec = 'x;
    prev_sclk = sclk_o;
    for (int e = 1; e <= ncyc; e++) begin
      step();
      if (busy_o) n_busy++;
      if (sclk_o != prev_sclk) begin
        n_tog++;
        if (first_tog < 0) first_tog = e;
        last_tog = e;
      end
      prev_sclk = sclk_o;
      if (lead_o) n_lead++;
      if (trail_o) n_trail++;
      if (done_o) begin n_done++; done_at = e; end
      if (sample_o != (pha ? trail_o : lead_o)) n_map_err++;
      if (shift_o != (pha ? lead_o : trail_o)) n_map_err++;
      if (lead_o && trail_o) n_map_err++;
      if (sample_o && sclk_o) n_samp_hi++;
      if (e >= abort_at && (lead_o || trail_o || sample_o || shift_o || done_o)) n_post++;
      if (mode == 1 && e == 10) begin div_i = 16'd0; bits_i = 6'd5; cpha_i = ~pha; start_i = 1'b1; end
      if (mode == 1 && e == 11) start_i = 1'b0;
      if (mode == 2 && e == abort_at) begin busy_abort = busy_o; sclk_abort = sclk_o; en_i = 1'b1; end
      if (mode == 2 && abort_at > e && n_lead + n_trail == 3) begin en_i = 1'b0; abort_at = e + 1; end
      if (mode == 3 && e == 7) begin
        rst_vec = {sclk_o, lead_o, trail_o, sample_o, shift_o, busy_o, done_o};
        rst_i = 1'b0;
      end
      if (mode == 3 && e == 6) rst_i = 1'b1;
    end
    busy_end = busy_o;
  endtask

  initial begin
    rst_i = 1'b1; en_i = 1'b1; start_i = 1'b0; cpol_i = 1'b1; cpha_i = 1'b0;
    div_i = '0; bits_i = '0;

    // Reset and idle level
    step(); step();
    check_eq("reset_outputs", {sclk_o, lead_o, trail_o, sample_o, shift_o, busy_o, done_o}, 0);
    rst_i = 1'b0;
    step();
    check_eq("idle_sclk_cpol1", sclk_o, 1);
    check_eq("idle_busy", busy_o, 0);

    // Mode 0, div=1, bits=8
    run(16'd1, 6'd8, 1'b0, 1'b0, 40, 0);
    check_eq("m0_first_edge", first_tog, 4);
    check_eq("m0_last_edge", last_tog, 34);
    check_eq("m0_edges", n_tog, 16);
    check_eq("m0_busy_cycles", n_busy, 35);
    check_eq("m0_done_at", done_at, 36);
    check_eq("m0_done_cnt", n_done, 1);
    check_eq("m0_lead", n_lead, 8);
    check_eq("m0_trail", n_trail, 8);
    check_eq("m0_strobe_map", n_map_err, 0);
    check_eq("m0_busy_end", busy_end, 0);

    // Mode 3 at max rate, div=0, bits=4
    step();
    run(16'd0, 6'd4, 1'b1, 1'b1, 14, 0);
    check_eq("m3_first_edge", first_tog, 2);
    check_eq("m3_last_edge", last_tog, 9);
    check_eq("m3_edges", n_tog, 8);
    check_eq("m3_done_at", done_at, 10);
    check_eq("m3_sample_on_rise", n_samp_hi, 4);
    check_eq("m3_strobe_map", n_map_err, 0);

    // Inputs changed and start re-pulsed mid-burst, div=3, bits=2
    step();
    run(16'd3, 6'd2, 1'b0, 1'b0, 40, 1);
    check_eq("lat_first_edge", first_tog, 8);
    check_eq("lat_last_edge", last_tog, 20);
    check_eq("lat_edges", n_tog, 4);
    check_eq("lat_done_cnt", n_done, 1);
    check_eq("lat_done_at", done_at, 24);
    check_eq("lat_busy_cycles", n_busy, 23);
    check_eq("lat_strobe_map", n_map_err, 0);

    // Abort after the third edge, div=1, bits=8, cpol=1
    step();
    run(16'd1, 6'd8, 1'b1, 1'b0, 20, 2);
    check_eq("abort_at", abort_at, 9);
    check_eq("abort_busy", busy_abort, 0);
    check_eq("abort_sclk", sclk_abort, 1);
    check_eq("abort_strobes", n_lead + n_trail, 3);
    check_eq("abort_post", n_post, 0);
    check_eq("abort_no_done", n_done, 0);

    // Full burst after the abort
    step();
    run(16'd1, 6'd8, 1'b1, 1'b0, 40, 0);
    check_eq("reburst_lead", n_lead, 8);
    check_eq("reburst_trail", n_trail, 8);
    check_eq("reburst_done_at", done_at, 36);

    // Zero-length transfer
    step();
    run(16'd5, 6'd0, 1'b0, 1'b0, 6, 0);
    check_eq("zero_done_at", done_at, 1);
    check_eq("zero_done_cnt", n_done, 1);
    check_eq("zero_edges", n_tog, 0);
    check_eq("zero_busy", n_busy, 0);

    // Longest burst, div=0, bits=63
    step();
    run(16'd0, 6'd63, 1'b0, 1'b1, 132, 0);
    check_eq("max_edges", n_tog, 126);
    check_eq("max_lead", n_lead, 63);
    check_eq("max_trail", n_trail, 63);
    check_eq("max_done_at", done_at, 128);

    // Reset asserted in RUN
    step();
    run(16'd1, 6'd8, 1'b1, 1'b0, 12, 3);
    check_eq("rst_run_outputs", rst_vec, 0);
    check_eq("rst_run_no_done", n_done, 0);
    check_eq("rst_run_busy_end", busy_end, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
